// File: rtl/reg_pair_writer.sv
// -----------------------------------------------------------------------------
// reg_pair_writer
//   Collects operand nibbles that arrive one at a time on entrada.
//   Each pair of LOAD commands forms one pair {operand1, operand2}.
//   Completed pairs go into a small FIFO of DEPTH entries. A consumer
//   drains that FIFO with pop.
//
// Ports
//   clock     : single clock, rising-edge active
//   reset     : synchronous, active-high; clears everything including overflow
//   tx[3:0]   : command (CLEAR / LOAD / HOLD; unknown codes behave as HOLD)
//   entrada   : operand nibble captured on LOAD
//   pop       : consumer removes the head pair (ignored when empty)
//   out1/out2 : head pair operands, 4'd0 when the buffer is empty
//   valid     : buffer non-empty
//   contador  : phase, 0 = expecting operand 1, 1 = expecting operand 2
//   full      : buffer holds DEPTH pairs
//   overflow  : sticky, a completed pair was dropped because the buffer was full
// -----------------------------------------------------------------------------
module reg_pair_writer #(
    parameter logic [3:0] CLEAR = 4'd0,
    parameter logic [3:0] LOAD  = 4'd1,
    parameter logic [3:0] HOLD  = 4'd2,
    parameter int         DEPTH = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] tx,
    input  logic [3:0] entrada,
    input  logic       pop,
    output logic [3:0] out1,
    output logic [3:0] out2,
    output logic       valid,
    output logic       contador,
    output logic       full,
    output logic       overflow
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic {
        ST_FIRST  = 1'b0,
        ST_SECOND = 1'b1
    } state_t;

    state_t          state_r;
    state_t          state_next_s;
    logic [3:0]      hold_r;
    logic [3:0]      hold_next_s;
    logic [7:0]      mem_r [DEPTH];
    logic [PW-1:0]   rd_ptr_r;
    logic [PW-1:0]   wr_ptr_r;
    logic [CW-1:0]   count_r;
    logic [PW-1:0]   rd_next_s;
    logic [PW-1:0]   wr_next_s;
    logic [CW-1:0]   count_next_s;
    logic [7:0]      head_r;
    logic [7:0]      head_next_s;
    logic            valid_r;
    logic            full_r;
    logic            overflow_r;
    logic            cmd_clear_s;
    logic            cmd_load_s;
    logic            pop_eff_s;
    logic            push_try_s;
    logic            push_s;
    logic            ovf_set_s;
    logic            full_now_s;
    logic [7:0]      pair_s;

    // Command decode: anything that is not CLEAR or LOAD leaves state alone.
    always_comb begin
        cmd_clear_s = 1'b0;
        cmd_load_s  = 1'b0;
        case (tx)
            CLEAR:   cmd_clear_s = 1'b1;
            LOAD:    cmd_load_s  = 1'b1;
            HOLD:    cmd_load_s  = 1'b0;
            default: cmd_load_s  = 1'b0;
        endcase
    end

    // Phase FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_FIRST;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Phase FSM next-state logic: each LOAD toggles the phase, CLEAR restarts it.
    always_comb begin
        state_next_s = state_r;
        if (cmd_clear_s) begin
            state_next_s = ST_FIRST;
        end else if (cmd_load_s) begin
            case (state_r)
                ST_FIRST:  state_next_s = ST_SECOND;
                ST_SECOND: state_next_s = ST_FIRST;
                default:   state_next_s = ST_FIRST;
            endcase
        end else begin
            state_next_s = state_r;
        end
    end

    // Phase FSM outputs.
    always_comb begin
        contador = (state_r == ST_SECOND) ? 1'b1 : 1'b0;
        out1     = head_r[7:4];
        out2     = head_r[3:0];
        valid    = valid_r;
        full     = full_r;
        overflow = overflow_r;
    end

    // Datapath next-state logic: FIFO bookkeeping and the look-ahead head value.
    always_comb begin
        full_now_s  = (count_r == DEPTH_C);
        pair_s      = {hold_r, entrada};
        // pop counts only when something is buffered and CLEAR does not override it.
        pop_eff_s   = pop && (count_r != {CW{1'b0}}) && !cmd_clear_s;
        push_try_s  = cmd_load_s && (state_r == ST_SECOND);
        // A full buffer still accepts a pair when the head leaves in the same cycle.
        push_s      = push_try_s && (!full_now_s || pop_eff_s);
        ovf_set_s   = push_try_s && full_now_s && !pop_eff_s;

        if (cmd_clear_s) begin
            hold_next_s = 4'd0;
        end else if (cmd_load_s && (state_r == ST_FIRST)) begin
            hold_next_s = entrada;
        end else begin
            hold_next_s = hold_r;
        end

        if (cmd_clear_s) begin
            rd_next_s    = {PW{1'b0}};
            wr_next_s    = {PW{1'b0}};
            count_next_s = {CW{1'b0}};
        end else begin
            rd_next_s = pop_eff_s ? (rd_ptr_r + 1'b1) : rd_ptr_r;
            wr_next_s = push_s    ? (wr_ptr_r + 1'b1) : wr_ptr_r;
            case ({push_s, pop_eff_s})
                2'b10:   count_next_s = count_r + 1'b1;
                2'b01:   count_next_s = count_r - 1'b1;
                default: count_next_s = count_r;
            endcase
        end

        // The head for the next cycle bypasses the memory when the slot being
        // written this cycle becomes the head (push into an empty or emptying buffer).
        if (count_next_s == {CW{1'b0}}) begin
            head_next_s = 8'd0;
        end else if (push_s && (wr_ptr_r == rd_next_s)) begin
            head_next_s = pair_s;
        end else begin
            head_next_s = mem_r[rd_next_s];
        end
    end

    // Datapath registers: hold nibble, pair storage, pointers and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            hold_r     <= 4'd0;
            rd_ptr_r   <= {PW{1'b0}};
            wr_ptr_r   <= {PW{1'b0}};
            count_r    <= {CW{1'b0}};
            head_r     <= 8'd0;
            valid_r    <= 1'b0;
            full_r     <= 1'b0;
            overflow_r <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 8'd0;
            end
        end else begin
            hold_r     <= hold_next_s;
            rd_ptr_r   <= rd_next_s;
            wr_ptr_r   <= wr_next_s;
            count_r    <= count_next_s;
            head_r     <= head_next_s;
            valid_r    <= (count_next_s != {CW{1'b0}});
            full_r     <= (count_next_s == DEPTH_C);
            overflow_r <= overflow_r | ovf_set_s;
            if (push_s) begin
                mem_r[wr_ptr_r] <= pair_s;
            end else begin
                mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
            end
        end
    end

endmodule

// File: tb/tb_reg_pair_writer.sv
module tb_reg_pair_writer;

    localparam logic [3:0] C_CLEAR = 4'd0;
    localparam logic [3:0] C_LOAD  = 4'd1;
    localparam logic [3:0] C_HOLD  = 4'd2;
    localparam int         DEPTH   = 4;

    logic       clock;
    logic       reset;
    logic [3:0] tx;
    logic [3:0] entrada;
    logic       pop;
    logic [3:0] out1;
    logic [3:0] out2;
    logic       valid;
    logic       contador;
    logic       full;
    logic       overflow;

    typedef struct packed {
        logic       v;
        logic [3:0] o1;
        logic [3:0] o2;
        logic       ph;
        logic       fu;
        logic       ov;
    } snap_t;

    snap_t exp_q[$];
    int    n_vec;
    int    n_err;
    int    cyc;

    // reference model state
    logic [7:0] m_q[$];
    logic       m_phase;
    logic [3:0] m_hold;
    logic       m_ovf;

    reg_pair_writer #(
        .CLEAR(C_CLEAR), .LOAD(C_LOAD), .HOLD(C_HOLD), .DEPTH(DEPTH)
    ) dut (
        .clock(clock), .reset(reset), .tx(tx), .entrada(entrada), .pop(pop),
        .out1(out1), .out2(out2), .valid(valid), .contador(contador),
        .full(full), .overflow(overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Apply one cycle of stimulus and queue the expected state after the edge.
    task automatic step(input logic r, input logic [3:0] t, input logic [3:0] e, input logic p);
        snap_t s;
        logic  popping;
        @(negedge clock);
        reset = r; tx = t; entrada = e; pop = p;
        if (r) begin
            m_q.delete();
            m_phase = 1'b0;
            m_hold  = 4'd0;
            m_ovf   = 1'b0;
        end else if (t == C_CLEAR) begin
            m_q.delete();
            m_phase = 1'b0;
        end else begin
            popping = p && (m_q.size() > 0);
            if (popping) void'(m_q.pop_front());
            if (t == C_LOAD) begin
                if (m_phase) begin
                    if (m_q.size() < DEPTH) m_q.push_back({m_hold, e});
                    else m_ovf = 1'b1;
                    m_phase = 1'b0;
                end else begin
                    m_hold  = e;
                    m_phase = 1'b1;
                end
            end
        end
        s.v  = (m_q.size() > 0);
        s.o1 = (m_q.size() > 0) ? m_q[0][7:4] : 4'd0;
        s.o2 = (m_q.size() > 0) ? m_q[0][3:0] : 4'd0;
        s.ph = m_phase;
        s.fu = (m_q.size() == DEPTH);
        s.ov = m_ovf;
        exp_q.push_back(s);
    endtask

    task automatic load(input logic [3:0] e, input logic p);
        step(1'b0, C_LOAD, e, p);
    endtask

    task automatic idle(input logic p);
        step(1'b0, C_HOLD, 4'd0, p);
    endtask

    // Monitor: after every rising edge compare the DUT against the oldest expectation.
    always begin
        snap_t e;
        snap_t a;
        @(posedge clock);
        #1;
        cyc++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = '{v: valid, o1: out1, o2: out2, ph: contador, fu: full, ov: overflow};
            n_vec++;
            if (a !== e) begin
                n_err++;
                $display("FAIL snapshot cycle %0d: got valid=%b out1=%0d out2=%0d contador=%b full=%b overflow=%b, want valid=%b out1=%0d out2=%0d contador=%b full=%b overflow=%b",
                         cyc, a.v, a.o1, a.o2, a.ph, a.fu, a.ov, e.v, e.o1, e.o2, e.ph, e.fu, e.ov);
            end
        end
    end

    initial begin
        logic [3:0] t;
        int         r;
        n_vec = 0; n_err = 0; cyc = 0;
        m_phase = 1'b0; m_hold = 4'd0; m_ovf = 1'b0;
        reset = 1'b1; tx = C_HOLD; entrada = 4'd0; pop = 1'b0;

        // reset state
        step(1'b1, C_HOLD, 4'd0, 1'b0);
        step(1'b1, C_LOAD, 4'd5, 1'b1);

        // basic pair
        load(4'd3, 1'b0); load(4'd9, 1'b0); idle(1'b0); idle(1'b1);

        // HOLD and unknown codes keep the phase
        load(4'd5, 1'b0);
        idle(1'b0);
        step(1'b0, 4'd5, 4'd11, 1'b0);
        step(1'b0, 4'd15, 4'd12, 1'b0);
        load(4'd6, 1'b0);
        step(1'b0, 4'd9, 4'd0, 1'b1);
        idle(1'b0);

        // fill, overflow, drain
        for (int i = 0; i < 4; i++) begin
            load(4'(i), 1'b0); load(4'(i + 8), 1'b0);
        end
        load(4'd12, 1'b0); load(4'd13, 1'b0);
        for (int i = 0; i < 5; i++) idle(1'b1);

        // full with simultaneous push and pop
        step(1'b1, C_HOLD, 4'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            load(4'(i + 4), 1'b0); load(4'(15 - i), 1'b0);
        end
        load(4'd10, 1'b0); load(4'd11, 1'b1);
        for (int i = 0; i < 5; i++) idle(1'b1);

        // CLEAR with buffered pairs and a partial pair
        load(4'd1, 1'b0); load(4'd4, 1'b0); load(4'd2, 1'b0); load(4'd8, 1'b0);
        load(4'd7, 1'b0);
        step(1'b0, C_CLEAR, 4'd3, 1'b1);
        load(4'd1, 1'b0); load(4'd2, 1'b0); idle(1'b0); idle(1'b1);

        // reset discards a partial pair; pop on empty has no effect
        load(4'd7, 1'b0);
        step(1'b1, C_LOAD, 4'd7, 1'b0);
        load(4'd1, 1'b0); load(4'd2, 1'b0); idle(1'b1); idle(1'b1); idle(1'b1);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            r = int'($urandom_range(0, 15));
            if (r == 0)       t = C_CLEAR;
            else if (r < 10)  t = C_LOAD;
            else if (r < 13)  t = C_HOLD;
            else              t = 4'($urandom_range(3, 15));
            step(($urandom_range(0, 79) == 0) ? 1'b1 : 1'b0, t,
                 4'($urandom_range(0, 15)), ($urandom_range(0, 9) < 4) ? 1'b1 : 1'b0);
        end

        // let the monitor consume the remaining expectations, bounded
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clock);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
